// File: rtl/rename_stage.sv
// Single-issue register rename: map table, one branch checkpoint,
// free-list pop and a registered valid/ready output stage.
module rename_stage #(
    parameter int NUM_AREGS = 32,
    parameter int NUM_PREGS = 128,
    parameter int PAYLOAD_W = 64,
    parameter int AREG_W    = $clog2(NUM_AREGS),
    parameter int PREG_W    = $clog2(NUM_PREGS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec_valid,
    output logic                 dec_ready,
    input  logic [AREG_W-1:0]    dec_rs1,
    input  logic [AREG_W-1:0]    dec_rs2,
    input  logic [AREG_W-1:0]    dec_rd,
    input  logic                 dec_rd_wen,
    input  logic                 dec_is_branch,
    input  logic [PAYLOAD_W-1:0] dec_payload,
    input  logic [PREG_W-1:0]    fl_pd_new,
    input  logic                 fl_empty,
    output logic                 fl_read_en,
    output logic                 ckpt_take,
    input  logic                 br_resolve,
    input  logic                 mispredict,
    output logic                 ren_valid,
    input  logic                 ren_ready,
    output logic [PREG_W-1:0]    ren_ps1,
    output logic [PREG_W-1:0]    ren_ps2,
    output logic [PREG_W-1:0]    ren_pd,
    output logic [PREG_W-1:0]    ren_pd_old,
    output logic                 ren_rd_wen,
    output logic                 ren_is_branch,
    output logic [PAYLOAD_W-1:0] ren_payload
);

    typedef enum logic {
        IDLE = 1'b0,
        HELD = 1'b1
    } ckpt_state_e;

    ckpt_state_e state_q, state_d;

    logic [PREG_W-1:0] map_q  [NUM_AREGS];
    logic [PREG_W-1:0] map_d  [NUM_AREGS];
    logic [PREG_W-1:0] ckpt_q [NUM_AREGS];
    logic [PREG_W-1:0] ckpt_d [NUM_AREGS];

    logic                 ren_valid_q, ren_valid_d;
    logic [PREG_W-1:0]    ren_ps1_q, ren_ps1_d;
    logic [PREG_W-1:0]    ren_ps2_q, ren_ps2_d;
    logic [PREG_W-1:0]    ren_pd_q, ren_pd_d;
    logic [PREG_W-1:0]    ren_pd_old_q, ren_pd_old_d;
    logic                 ren_rd_wen_q, ren_rd_wen_d;
    logic                 ren_is_branch_q, ren_is_branch_d;
    logic [PAYLOAD_W-1:0] ren_payload_q, ren_payload_d;

    logic alloc;
    logic stall;
    logic fire;
    logic flush;
    logic take;

    always_comb begin
        alloc = dec_rd_wen && (dec_rd != '0);
        stall = mispredict
             || (alloc && fl_empty)
             || (dec_is_branch && state_q == HELD);
        dec_ready = (!ren_valid_q || ren_ready) && !stall && !reset;
        fire = dec_valid && dec_ready;
        flush = br_resolve && mispredict && (state_q == HELD);
        // Branches stall while HELD, so a firing branch is always from IDLE.
        take = fire && dec_is_branch && (state_q == IDLE);
    end

    assign fl_read_en = fire && alloc;
    assign ckpt_take  = take;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (take) state_d = HELD;
            HELD: if (br_resolve) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        map_d = map_q;
        if (flush) begin
            map_d = ckpt_q;
        end else if (fire && alloc) begin
            map_d[dec_rd] = fl_pd_new;
        end
    end

    // The snapshot already includes the branch's own rd update.
    always_comb begin
        ckpt_d = ckpt_q;
        if (take) ckpt_d = map_d;
    end

    always_comb begin
        ren_valid_d     = ren_valid_q;
        ren_ps1_d       = ren_ps1_q;
        ren_ps2_d       = ren_ps2_q;
        ren_pd_d        = ren_pd_q;
        ren_pd_old_d    = ren_pd_old_q;
        ren_rd_wen_d    = ren_rd_wen_q;
        ren_is_branch_d = ren_is_branch_q;
        ren_payload_d   = ren_payload_q;
        if (flush) begin
            ren_valid_d = 1'b0;
        end else if (fire) begin
            ren_valid_d     = 1'b1;
            ren_ps1_d       = map_q[dec_rs1];
            ren_ps2_d       = map_q[dec_rs2];
            ren_pd_d        = alloc ? fl_pd_new : '0;
            ren_pd_old_d    = alloc ? map_q[dec_rd] : '0;
            ren_rd_wen_d    = alloc;
            ren_is_branch_d = dec_is_branch;
            ren_payload_d   = dec_payload;
        end else if (ren_ready) begin
            ren_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_AREGS; i++) begin
                map_q[i]  <= PREG_W'(i);
                ckpt_q[i] <= PREG_W'(i);
            end
            ren_valid_q     <= 1'b0;
            ren_ps1_q       <= '0;
            ren_ps2_q       <= '0;
            ren_pd_q        <= '0;
            ren_pd_old_q    <= '0;
            ren_rd_wen_q    <= 1'b0;
            ren_is_branch_q <= 1'b0;
            ren_payload_q   <= '0;
        end else begin
            state_q         <= state_d;
            map_q           <= map_d;
            ckpt_q          <= ckpt_d;
            ren_valid_q     <= ren_valid_d;
            ren_ps1_q       <= ren_ps1_d;
            ren_ps2_q       <= ren_ps2_d;
            ren_pd_q        <= ren_pd_d;
            ren_pd_old_q    <= ren_pd_old_d;
            ren_rd_wen_q    <= ren_rd_wen_d;
            ren_is_branch_q <= ren_is_branch_d;
            ren_payload_q   <= ren_payload_d;
        end
    end

    assign ren_valid     = ren_valid_q;
    assign ren_ps1       = ren_ps1_q;
    assign ren_ps2       = ren_ps2_q;
    assign ren_pd        = ren_pd_q;
    assign ren_pd_old    = ren_pd_old_q;
    assign ren_rd_wen    = ren_rd_wen_q;
    assign ren_is_branch = ren_is_branch_q;
    assign ren_payload   = ren_payload_q;

endmodule

// File: doc/rename_stage.md
Name: rename_stage

Overview:
- Single-issue register-rename stage, between decode (upstream) and dispatch (downstream).
- Directly consumes the physical-register free list: pops one preg per renamed destination.
- Holds the 32-entry architectural-to-physical map table, with one branch checkpoint that is restored on mispredict.
- Outputs are registered, using a valid/ready handshake on both sides.

Parameters:
- NUM_AREGS, 32, architectural registers (x0-x31).
- NUM_PREGS, 128, physical registers; PREG_W = $clog2(NUM_PREGS) = 7.
- PAYLOAD_W, 64, opaque decode payload carried alongside the instruction (opcode, imm, pc, ...).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- dec_valid  in  1  decode presents an instruction
- dec_ready  out  1  rename accepts this cycle
- dec_rs1, dec_rs2  in  5 each  source architectural regs
- dec_rd  in  5  destination architectural reg
- dec_rd_wen  in  1  instruction writes rd
- dec_is_branch  in  1  instruction needs a checkpoint
- dec_payload  in  PAYLOAD_W  passthrough
- fl_pd_new  in  PREG_W  head of free list (combinational)
- fl_empty  in  1  free list empty
- fl_read_en  out  1  pop free-list head this cycle
- ckpt_take  out  1  pulse: free list and other units snapshot now
- br_resolve  in  1  outstanding branch resolved this cycle
- mispredict  in  1  resolved branch mispredicted (only with br_resolve)
- ren_valid  out  1  renamed instruction valid
- ren_ready  in  1  dispatch accepts
- ren_ps1, ren_ps2  out  PREG_W each  physical sources
- ren_pd  out  PREG_W  new physical dest (0 if no alloc)
- ren_pd_old  out  PREG_W  previous mapping of rd, freed at commit (0 if no alloc)
- ren_rd_wen  out  1  allocation performed
- ren_is_branch  out  1  passthrough
- ren_payload  out  PAYLOAD_W  passthrough

Behaviour:
- alloc = dec_rd_wen && dec_rd != 0. x0 is never renamed; ps for x0 reads as map[0] = 0.
- stall = mispredict || (alloc && fl_empty) || (dec_is_branch && ckpt_state == HELD).
- dec_ready = (!ren_valid || ren_ready) && !stall, computed combinationally. fire = dec_valid && dec_ready.
- fl_read_en = fire && alloc. Never asserted when fl_empty.
- On fire (registered, latency 1):
  - ren_ps1/ps2 = map[rs1]/map[rs2], read before this instruction's own update.
  - ren_pd_old = map[rd].
  - ren_pd = fl_pd_new.
  - map[rd] <= fl_pd_new if alloc.
  - ren_valid <= 1.
- No fire and ren_ready: ren_valid <= 0. Otherwise the output register holds all fields stable while ren_valid && !ren_ready.
- Back-to-back dependent instructions need no bypass: the map update lands at the same edge the producer fires.
- Checkpoint FSM, states IDLE / HELD:
  - IDLE, fire with dec_is_branch: ckpt <= map with this instruction's rd update applied; ckpt_take = 1 combinationally that cycle; -> HELD.
  - HELD, br_resolve && !mispredict: -> IDLE, checkpoint discarded.
  - HELD, br_resolve && mispredict: map <= ckpt; ren_valid <= 0; -> IDLE. No fire this cycle.
  - A second branch stalls in HELD, including in the resolve cycle. It may fire from the next cycle.
  - br_resolve in IDLE is ignored.
- Mispredict has priority over any fire and over ren_ready/hold; the output register is flushed unconditionally.
- Reset:
  - map[i] = i and ckpt[i] = i for all i, matching free-list preg allocation starting at 32.
  - ckpt_state = IDLE.
  - ren_valid = 0; all ren_* data outputs = 0; ckpt_take = 0; fl_read_en = 0.
  - Reset mid-stall or while HELD discards everything.
- All preg fields are PREG_W bits. No arithmetic beyond indexing.

Test Plan:
- Reset, then `add x5,x1,x2` (rd_wen) with fl_pd_new=32 -> next cycle ren_ps1=1, ren_ps2=2, ren_pd=32, ren_pd_old=5, fl_read_en pulsed once.
- Back-to-back: `x5<=..` (pd 32), then `x6<=x5+x5` (pd 33) -> second has ps1=ps2=32, pd_old=6. A third `x5<=..` (pd 34) -> pd_old=32.
- rd=x0 with rd_wen=1, and fl_empty=1 with alloc -> x0 case: no fl_read_en, pd=0, pd_old=0. Empty case: dec_ready=0 until fl_empty drops, then fires.
- ren_ready held low for 3 cycles with dec_valid high -> ren_* stable, dec_ready=0, no fl_read_en. Release -> one transfer per cycle resumes.
- Branch fires (ckpt_take=1, HELD), then x7->40, then a second branch stalls; assert br_resolve+mispredict -> ren_valid=0 next cycle, map[7]=7 (pre-x7 value), IDLE, stalled branch fires the following cycle.
- Branch, then br_resolve with mispredict=0 -> IDLE, later renames keep x7->40 mapping, next branch takes a new checkpoint.
